// File: rtl/multi_port_block_ram.sv
// Shared word array serving NUM_PORTS requesters through a round-robin arbiter,
// with per-byte write strobes, fixed access latency and out-of-range error pulses.

`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 32
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif

module multi_port_block_ram #(
  parameter int unsigned NUM_PORTS     = 2,
  parameter int unsigned MADDR_WIDTH   = `DEFAULT_MADDR_WIDTH,
  parameter int unsigned MDATA_WIDTH   = `DEFAULT_MDATA_WIDTH,
  parameter int unsigned SIZE_IN_BYTES = 4096,
  parameter int unsigned DELAY         = 10
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_PORTS-1:0]               mem_read_enable,
  input  logic [NUM_PORTS-1:0]               mem_write_enable,
  input  logic [NUM_PORTS*MADDR_WIDTH-1:0]   mem_addr,
  input  logic [NUM_PORTS*MDATA_WIDTH-1:0]   mem_write_data,
  input  logic [NUM_PORTS*MDATA_WIDTH/8-1:0] mem_write_strobe,
  output logic [NUM_PORTS*MDATA_WIDTH-1:0]   mem_read_data,
  output logic [NUM_PORTS-1:0]               mem_read_ready,
  output logic [NUM_PORTS-1:0]               mem_write_ready,
  output logic [NUM_PORTS-1:0]               mem_error
);

  localparam int unsigned BYTES  = MDATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(BYTES);
  localparam int unsigned WORDS  = SIZE_IN_BYTES / BYTES;
  localparam int unsigned ARR_AW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned IDX_W  = MADDR_WIDTH - OFF_W;
  localparam int unsigned CNT_W  = $clog2(DELAY + 1);
  localparam int unsigned PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [MDATA_WIDTH-1:0] mem [WORDS];

  logic [CNT_W-1:0]       cnt_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [PTR_W-1:0]       gnt_q;
  logic                   op_write_q;
  logic [IDX_W-1:0]       idx_q;
  logic [MDATA_WIDTH-1:0] wdata_q;
  logic [BYTES-1:0]       strb_q;

  logic [NUM_PORTS-1:0]   req_c;
  logic                   arb_valid_c;
  logic [PTR_W-1:0]       arb_port_c;
  logic [MADDR_WIDTH-1:0] addr_c;
  logic [IDX_W-1:0]       word_c;
  logic                   grant_c;
  logic                   access_c;
  logic                   resp_c;
  logic                   oor_c;
  logic [MDATA_WIDTH-1:0] rd_word_c;

  // Round-robin pick: first requester at or above the pointer, else wrap from port 0.
  always_comb begin
    req_c       = mem_read_enable | mem_write_enable;
    arb_valid_c = 1'b0;
    arb_port_c  = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (!arb_valid_c && req_c[i] && (PTR_W'(i) >= ptr_q)) begin
        arb_valid_c = 1'b1;
        arb_port_c  = PTR_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (!arb_valid_c && req_c[i]) begin
        arb_valid_c = 1'b1;
        arb_port_c  = PTR_W'(i);
      end
    end
    addr_c = mem_addr[arb_port_c*MADDR_WIDTH +: MADDR_WIDTH];
    word_c = IDX_W'(addr_c >> OFF_W);
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_valid_c) state_d = BUSY;
      BUSY:    if (cnt_q == CNT_W'(DELAY - 1)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    grant_c  = 1'b0;
    access_c = 1'b0;
    resp_c   = 1'b0;
    case (state_q)
      IDLE:    grant_c  = arb_valid_c;
      BUSY:    access_c = (cnt_q == CNT_W'(DELAY - 1));
      RESP:    resp_c   = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    oor_c     = (idx_q >= IDX_W'(WORDS));
    rd_word_c = oor_c ? '0 : mem[idx_q[ARR_AW-1:0]];
  end

  // Request latch, counter, pointer and registered responses
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q           <= '0;
      ptr_q           <= '0;
      gnt_q           <= '0;
      op_write_q      <= 1'b0;
      idx_q           <= '0;
      wdata_q         <= '0;
      strb_q          <= '0;
      mem_read_data   <= '0;
      mem_read_ready  <= '0;
      mem_write_ready <= '0;
      mem_error       <= '0;
    end else begin
      mem_read_ready  <= '0;
      mem_write_ready <= '0;
      mem_error       <= '0;
      if (grant_c) begin
        cnt_q      <= '0;
        gnt_q      <= arb_port_c;
        op_write_q <= mem_write_enable[arb_port_c];
        idx_q      <= word_c;
        wdata_q    <= mem_write_data[arb_port_c*MDATA_WIDTH +: MDATA_WIDTH];
        strb_q     <= mem_write_strobe[arb_port_c*BYTES +: BYTES];
      end
      if (state_q == BUSY) cnt_q <= cnt_q + CNT_W'(1);
      if (access_c) begin
        if (op_write_q) begin
          mem_write_ready[gnt_q] <= 1'b1;
        end else begin
          mem_read_ready[gnt_q] <= 1'b1;
          mem_read_data[gnt_q*MDATA_WIDTH +: MDATA_WIDTH] <= rd_word_c;
        end
        if (oor_c) mem_error[gnt_q] <= 1'b1;
      end
      if (resp_c) begin
        if (gnt_q == PTR_W'(NUM_PORTS - 1)) ptr_q <= '0;
        else                                ptr_q <= gnt_q + PTR_W'(1);
      end
    end
  end

  // Array contents survive reset; an aborted access never reaches this write.
  always_ff @(posedge clock) begin
    if (!reset && access_c && op_write_q && !oor_c) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (strb_q[b]) mem[idx_q[ARR_AW-1:0]][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

endmodule

// File: doc/multi_port_block_ram.md
Name: multi_port_block_ram

Overview:
- Parametrised successor to the single-port delayed block RAM simulation model.
- Serves NUM_PORTS independent requesters from one shared word array.
- Adds round-robin arbitration, per-byte write strobes, configurable latency and out-of-range error reporting.
- Sits between the cache/fetch/load-store masters and backing memory in testbenches; the structure is also synthesizable.

Parameters:
- NUM_PORTS, 2, number of requester channels (1..8).
- MADDR_WIDTH, `DEFAULT_MADDR_WIDTH, byte-address width per port.
- MDATA_WIDTH, `DEFAULT_MDATA_WIDTH, data word width; a multiple of 8.
- SIZE_IN_BYTES, 4096, array size; a multiple of MDATA_WIDTH/8.
- DELAY, 10, cycles from grant to ready; must be >= 1.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- mem_read_enable  in  NUM_PORTS  per-port read request, level, held until ready.
- mem_write_enable  in  NUM_PORTS  per-port write request, level, held until ready.
- mem_addr  in  NUM_PORTS*MADDR_WIDTH  per-port byte address; port p occupies slice p.
- mem_write_data  in  NUM_PORTS*MDATA_WIDTH  per-port write data.
- mem_write_strobe  in  NUM_PORTS*MDATA_WIDTH/8  per-port byte enables.
- mem_read_data  out  NUM_PORTS*MDATA_WIDTH  per-port read result (registered).
- mem_read_ready  out  NUM_PORTS  one-cycle pulse when a read completes.
- mem_write_ready  out  NUM_PORTS  one-cycle pulse when a write completes.
- mem_error  out  NUM_PORTS  one-cycle pulse, coincident with ready, on an out-of-range access.

Behaviour:
- Reset:
  - All ready and error outputs = 0; mem_read_data = 0.
  - FSM = IDLE; round-robin pointer = 0.
  - Array contents are not cleared.
  - Reset mid-access aborts the access: no array write, no ready.
- FSM states:
  - IDLE: at an edge where any enable bit is high, grant the first requesting port at or after the pointer, scanning upward with wrap. Latch the grant's op, word index, data and strobe. Set count = 0 and go to BUSY.
  - BUSY: count increments each edge. At the edge where count == DELAY-1, perform the access, pulse ready (and error if applicable) for the granted port, and go to RESP.
  - RESP: ready/error return to 0 at the next edge. Pointer = granted port + 1 (mod NUM_PORTS). Go to IDLE.
- Timing:
  - Ready is visible DELAY cycles after the grant edge.
  - Back-to-back accesses cost DELAY+2 cycles each.
  - Enables are ignored during BUSY and RESP.
  - The latched request is used for the whole access; input changes after grant have no effect.
- Request rules:
  - Write has priority over read when both enables on one port are high; the read stays pending.
  - A requester must drop its enable in the cycle after ready, or it issues a new request.
- Addressing:
  - Word index = mem_addr >> log2(MDATA_WIDTH/8); low address bits are ignored (aligned access).
  - Out of range (word index >= SIZE_IN_BYTES*8/MDATA_WIDTH): write is discarded, read returns 0, mem_error pulses.
- Write: only bytes with a strobe bit set are updated. An all-zero strobe still completes with mem_write_ready.
- Read: mem_read_data for the granted port updates at the completion edge and holds until that port's next read completion. Other ports' data is unchanged.
- Counter and pointer widths are sized by $clog2 of DELAY+1 and NUM_PORTS; there is no overflow path.

Test Plan:
- Port 0 writes addr 0x10, data 0xDEADBEEF, strobe 0xF; then reads 0x10 -> mem_write_ready[0] pulses exactly 10 cycles after grant, then mem_read_ready[0] pulses with data 0xDEADBEEF.
- Write 0x11223344, then write 0xAABBCCDD with strobe 0x5 to the same address, then read -> 0x11BB33DD.
- Ports 0 and 1 both raise read at the same edge after reset -> port 0 served first, then port 1. Repeat both requests -> port 1 is then served before port 0 (round-robin).
- Read byte addr SIZE_IN_BYTES (4096) -> mem_read_ready and mem_error pulse together; data 0. A write to the same address leaves the array unchanged.
- Assert reset at count 5 of a write -> no ready; a subsequent read of that address returns its old value.
- Write and read enables high together on port 1 -> the write completes first; the read then completes DELAY+2 cycles later, returning the newly written value.
